// File: rtl/echo_emu_pkg.sv
// Shared types and constants for the echo target emulator.
//
// Contents:
//   state_e        - FSM states (StHoldoff only exists when ECHO_HOLDOFF_EN is defined)
//   BCD_MAX_DIGIT  - largest legal BCD digit
//   MAX_DIST       - largest programmable distance
//   DCNT_W         - width of the round-trip delay counter (holds 2*MAX_DIST)
//   DIST_W         - width of the binary distance
//   digit_ok()     - true when a 4-bit nibble is a legal BCD digit
//
// Optional feature macro: ECHO_HOLDOFF_EN (adds the dead-time state after each echo).
package echo_emu_pkg;

    localparam int unsigned BCD_MAX_DIGIT = 9;
    localparam int unsigned MAX_DIST      = 999;
    localparam int unsigned DCNT_W        = 11;
    localparam int unsigned DIST_W        = 10;

`ifdef ECHO_HOLDOFF_EN
    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StEcho,
        StHoldoff
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StEcho
    } state_e;
`endif

    function automatic logic digit_ok(input logic [3:0] digit);
        return digit <= 4'(BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd3_to_bin.sv
// Combinational three-digit BCD to binary converter.
//
// Ports:
//   bcd_i    in   12  {hundreds, tens, ones}, BCD
//   bin_o    out  10  100*h + 10*t + o (meaningless when valid_o is low)
//   valid_o  out  1   every digit is in 0..9
module bcd3_to_bin
    import echo_emu_pkg::*;
(
    input  logic [11:0]       bcd_i,
    output logic [DIST_W-1:0] bin_o,
    output logic              valid_o
);

    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;

    always_comb begin
        hundreds = bcd_i[11:8];
        tens     = bcd_i[7:4];
        ones     = bcd_i[3:0];

        bin_o = DIST_W'(hundreds) * DIST_W'(100)
              + DIST_W'(tens) * DIST_W'(10)
              + DIST_W'(ones);

        // An illegal digit can wrap the sum back into range, so the digit test is what counts;
        // the range test only documents the legal output span.
        valid_o = digit_ok(hundreds) && digit_ok(tens) && digit_ok(ones)
               && (32'(bin_o) <= MAX_DIST);
    end

endmodule

// File: rtl/echo_target_emulator.sv
// Programmable far-end target for the time-of-flight ranging link.
//
// A rising edge on trig (while idle, with a legal BCD distance D) starts a round trip: after
// 2*D time ticks the module raises echo for ECHO_CYCLES clocks. A tick is TICK_DIV clocks.
// An accepted trigger at clock edge A gives an echo rising at edge A + 2*D*TICK_DIV + 1.
//
// Ports:
//   clk       in   1   system clock
//   reset     in   1   asynchronous, active-low reset
//   trig      in   1   ranging pulse from the initiator (synchronous to clk)
//   dist_bcd  in   12  target distance {hundreds, tens, ones}, BCD, sampled on acceptance
//   echo      out  1   returned pulse
//   busy      out  1   round trip in progress; triggers are ignored while high
//   dist_bin  out  10  binary distance latched at the last accepted trigger
//   err       out  1   one-cycle pulse when a trigger is rejected for an illegal digit
//
// Parameters:
//   TICK_DIV       clk cycles per time tick
//   ECHO_CYCLES    echo pulse width in clk cycles (>= 1)
//   HOLDOFF_TICKS  dead-time ticks after the echo (only present with ECHO_HOLDOFF_EN)
//
// Optional feature macro: ECHO_HOLDOFF_EN. When defined, the echo is followed by a HOLDOFF
// state of HOLDOFF_TICKS ticks during which busy stays high. When undefined, busy falls on
// the same edge as echo.
module echo_target_emulator
    import echo_emu_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 100_000_000,
    parameter int unsigned ECHO_CYCLES   = 4
`ifdef ECHO_HOLDOFF_EN
    ,
    parameter int unsigned HOLDOFF_TICKS = 2
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trig,
    input  logic [11:0]       dist_bcd,
    output logic              echo,
    output logic              busy,
    output logic [DIST_W-1:0] dist_bin,
    output logic              err
);

    localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned ECNT_W = (ECHO_CYCLES > 1) ? $clog2(ECHO_CYCLES) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [ECNT_W-1:0] ECNT_LOAD = ECNT_W'(ECHO_CYCLES - 1);

`ifdef ECHO_HOLDOFF_EN
    localparam int unsigned HCNT_W = (HOLDOFF_TICKS > 1) ? $clog2(HOLDOFF_TICKS + 1) : 1;
    localparam logic [HCNT_W-1:0] HCNT_LOAD = HCNT_W'(HOLDOFF_TICKS);
`endif

    // ------------------------------------------------------------------------
    // Distance decode
    // ------------------------------------------------------------------------
    logic [DIST_W-1:0] bcd_bin;
    logic              bcd_valid;

    bcd3_to_bin u_bcd3_to_bin (
        .bcd_i   (dist_bcd),
        .bin_o   (bcd_bin),
        .valid_o (bcd_valid)
    );

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e              state_q, state_d;
    logic                trig_q;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [ECNT_W-1:0]   ecnt_q, ecnt_d;
    logic                echo_q, echo_d;
    logic                busy_q, busy_d;
    logic [DIST_W-1:0]   dist_q, dist_d;
    logic                err_q, err_d;
`ifdef ECHO_HOLDOFF_EN
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
`endif

    logic rise;
    logic counting;
    logic tick;

    assign rise = trig & ~trig_q;

`ifdef ECHO_HOLDOFF_EN
    assign counting = (state_q == StDelay) || (state_q == StHoldoff);
`else
    assign counting = (state_q == StDelay);
`endif

    // The prescaler only runs in the timed states; it sits at zero everywhere else, so entering
    // DELAY or HOLDOFF always starts a fresh, full tick period.
    assign tick = counting && (pre_q == PRE_LAST);

    always_comb begin
        state_d = state_q;
        pre_d   = counting ? (tick ? '0 : pre_q + 1'b1) : '0;
        dcnt_d  = dcnt_q;
        ecnt_d  = ecnt_q;
        echo_d  = echo_q;
        busy_d  = busy_q;
        dist_d  = dist_q;
        err_d   = 1'b0;
`ifdef ECHO_HOLDOFF_EN
        hcnt_d  = hcnt_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    if (bcd_valid) begin
                        dist_d  = bcd_bin;
                        dcnt_d  = {bcd_bin, 1'b0};
                        busy_d  = 1'b1;
                        state_d = StDelay;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            StDelay: begin
                // Zero check comes first so that D = 0 leaves without consuming a tick.
                if (dcnt_q == '0) begin
                    state_d = StEcho;
                    echo_d  = 1'b1;
                    ecnt_d  = ECNT_LOAD;
                end else if (tick) begin
                    dcnt_d = dcnt_q - 1'b1;
                end
            end

            StEcho: begin
                if (ecnt_q == '0) begin
                    echo_d = 1'b0;
`ifdef ECHO_HOLDOFF_EN
                    hcnt_d  = HCNT_LOAD;
                    state_d = StHoldoff;
`else
                    busy_d  = 1'b0;
                    state_d = StIdle;
`endif
                end else begin
                    ecnt_d = ecnt_q - 1'b1;
                end
            end

`ifdef ECHO_HOLDOFF_EN
            StHoldoff: begin
                if (tick) begin
                    if (hcnt_q <= HCNT_W'(1)) begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        hcnt_d = hcnt_q - 1'b1;
                    end
                end
            end
`endif

            default: begin
                state_d = StIdle;
                echo_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            trig_q  <= 1'b0;
            pre_q   <= '0;
            dcnt_q  <= '0;
            ecnt_q  <= '0;
            echo_q  <= 1'b0;
            busy_q  <= 1'b0;
            dist_q  <= '0;
            err_q   <= 1'b0;
`ifdef ECHO_HOLDOFF_EN
            hcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            trig_q  <= trig;
            pre_q   <= pre_d;
            dcnt_q  <= dcnt_d;
            ecnt_q  <= ecnt_d;
            echo_q  <= echo_d;
            busy_q  <= busy_d;
            dist_q  <= dist_d;
            err_q   <= err_d;
`ifdef ECHO_HOLDOFF_EN
            hcnt_q  <= hcnt_d;
`endif
        end
    end

    assign echo     = echo_q;
    assign busy     = busy_q;
    assign dist_bin = dist_q;
    assign err      = err_q;

endmodule

// File: tb/tb_echo_target_emulator.sv
// Self-checking bench for echo_target_emulator.
// A trip-level model predicts echo/busy/dist_bin/err from trigger times and the distance
// arithmetic; a compare process checks it every falling edge. Directed tests add literal
// cycle-exact expectations. Honours ECHO_HOLDOFF_EN when defined.
module tb_echo_target_emulator;

    localparam int unsigned TICK_DIV      = 4;
    localparam int unsigned ECHO_CYCLES   = 3;
    localparam int unsigned HOLDOFF_TICKS = 2;
`ifdef ECHO_HOLDOFF_EN
    localparam int HOLD_CYC = HOLDOFF_TICKS * TICK_DIV;
`else
    localparam int HOLD_CYC = 0;
`endif

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       trig     = 1'b0;
    logic [11:0] dist_bcd = 12'h000;
    logic       echo;
    logic       busy;
    logic [9:0] dist_bin;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int a       = 0;

    always #5 clk = ~clk;

    echo_target_emulator #(
        .TICK_DIV      (TICK_DIV),
        .ECHO_CYCLES   (ECHO_CYCLES)
`ifdef ECHO_HOLDOFF_EN
        ,
        .HOLDOFF_TICKS (HOLDOFF_TICKS)
`endif
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .trig     (trig),
        .dist_bcd (dist_bcd),
        .echo     (echo),
        .busy     (busy),
        .dist_bin (dist_bin),
        .err      (err)
    );

    // Edge counter: after rising edge n (and before the next one) cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic bit bcd_ok(input logic [11:0] b);
        return (b[11:8] <= 4'd9) && (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    function automatic int bcd_val(input logic [11:0] b);
        return 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
    endfunction

    // ---------------- trip-level model ----------------
    bit m_active = 1'b0;
    bit m_prev   = 1'b0;
    bit m_rise;
    int m_on     = 0;
    int m_off    = 0;
    int m_free   = 0;
    int m_n;
    int m_d;
    bit e_echo   = 1'b0;
    bit e_busy   = 1'b0;
    bit e_err    = 1'b0;
    int e_dist   = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active = 1'b0;
            m_prev   = 1'b0;
            e_echo   = 1'b0;
            e_busy   = 1'b0;
            e_err    = 1'b0;
            e_dist   = 0;
        end else begin
            m_n    = cyc + 1;
            m_rise = trig && !m_prev;
            m_prev = trig;
            e_err  = 1'b0;
            if (!m_active && m_rise) begin
                if (bcd_ok(dist_bcd)) begin
                    m_d      = bcd_val(dist_bcd);
                    m_active = 1'b1;
                    m_on     = m_n + 2 * m_d * TICK_DIV + 1;
                    m_off    = m_on + ECHO_CYCLES;
                    m_free   = m_off + HOLD_CYC;
                    e_dist   = m_d;
                end else begin
                    e_err = 1'b1;
                end
            end else if (m_active && m_n >= m_free) begin
                m_active = 1'b0;
            end
            e_busy = m_active;
            e_echo = m_active && (m_n >= m_on) && (m_n < m_off);
        end
    end

    always @(negedge clk) begin
        check("cmp_echo", int'(echo), int'(e_echo));
        check("cmp_busy", int'(busy), int'(e_busy));
        check("cmp_err", int'(err), int'(e_err));
        check("cmp_dist", int'(dist_bin), e_dist);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) step();
    endtask

    // Raise trig now; the next rising edge is the acceptance edge, returned in a.
    task automatic fire(input logic [11:0] bcd);
        dist_bcd = bcd;
        trig     = 1'b1;
        a        = cyc + 1;
        step();
        trig     = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (3) step();
        check("rst_echo", int'(echo), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_dist", int'(dist_bin), 0);
        check("rst_err", int'(err), 0);
        reset = 1'b1;
        repeat (2) step();

        // D = 12, distance input changed mid-trip
        fire(12'h012);
        check("d12_busy_at_a", int'(busy), 1);
        check("d12_dist", int'(dist_bin), 12);
        wait_cyc(a + 5);
        dist_bcd = 12'h999;
        wait_cyc(a + 96);
        check("d12_echo_before", int'(echo), 0);
        wait_cyc(a + 97);
        check("d12_echo_rise", int'(echo), 1);
        wait_cyc(a + 99);
        check("d12_echo_last", int'(echo), 1);
        wait_cyc(a + 100);
        check("d12_echo_fall", int'(echo), 0);
        check("d12_dist_kept", int'(dist_bin), 12);
        wait_cyc(a + 100 + HOLD_CYC);
        check("d12_busy_fall", int'(busy), 0);
        step();

        // Illegal digit: rejected, dist_bin keeps 12
        fire(12'h1A3);
        check("bad_err", int'(err), 1);
        check("bad_busy", int'(busy), 0);
        check("bad_dist", int'(dist_bin), 12);
        step();
        check("bad_err_pulse", int'(err), 0);
        wait_cyc(a + 30);
        check("bad_no_echo", int'(echo), 0);

        // D = 0: no tick consumed
        fire(12'h000);
        check("d0_busy", int'(busy), 1);
        check("d0_echo_at_a", int'(echo), 0);
        wait_cyc(a + 1);
        check("d0_echo_rise", int'(echo), 1);
        wait_cyc(a + 3);
        check("d0_echo_last", int'(echo), 1);
        wait_cyc(a + 4);
        check("d0_echo_fall", int'(echo), 0);
        wait_cyc(a + 4 + HOLD_CYC);
        check("d0_busy_fall", int'(busy), 0);
        step();

        // D = 5, retrigger while busy, then trig held high past the trip
        fire(12'h005);
        wait_cyc(a + 9);
        trig = 1'b1;
        wait_cyc(a + 10);
        check("d5_retrig_err", int'(err), 0);
        wait_cyc(a + 40);
        check("d5_echo_before", int'(echo), 0);
        wait_cyc(a + 41);
        check("d5_echo_rise", int'(echo), 1);
        wait_cyc(a + 44 + HOLD_CYC);
        check("d5_busy_fall", int'(busy), 0);
        wait_cyc(a + 80);
        check("d5_held_busy", int'(busy), 0);
        check("d5_held_echo", int'(echo), 0);
        trig = 1'b0;
        step();

        // Reset in the middle of a 999 trip
        fire(12'h999);
        wait_cyc(a + 20);
        reset = 1'b0;
        #1;
        check("rst_mid_echo", int'(echo), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_dist", int'(dist_bin), 0);
        repeat (2) step();
        reset = 1'b1;
        step();
        fire(12'h999);
        check("d999_dist", int'(dist_bin), 999);
        wait_cyc(a + 7992);
        check("d999_echo_before", int'(echo), 0);
        check("d999_busy", int'(busy), 1);
        wait_cyc(a + 7993);
        check("d999_echo_rise", int'(echo), 1);
        wait_cyc(a + 7996 + HOLD_CYC);
        check("d999_busy_fall", int'(busy), 0);
        step();

`ifdef ECHO_HOLDOFF_EN
        // Hold-off window: trigger inside it is ignored
        fire(12'h001);
        wait_cyc(a + 9);
        check("ho_echo_rise", int'(echo), 1);
        wait_cyc(a + 12);
        check("ho_echo_fall", int'(echo), 0);
        check("ho_busy_hold", int'(busy), 1);
        wait_cyc(a + 13);
        trig = 1'b1;
        step();
        trig = 1'b0;
        wait_cyc(a + 19);
        check("ho_busy_last", int'(busy), 1);
        wait_cyc(a + 20);
        check("ho_busy_fall", int'(busy), 0);
        wait_cyc(a + 40);
        check("ho_no_echo", int'(echo), 0);
        step();
`endif

        repeat (5) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected under 20000",
                 cyc);
        $fatal(1, "watchdog");
    end

endmodule
